regn_wr_arbiter: RTL and testbench
==================================

# regn_wr_arbiter

- Round-robin write arbiter and sequencer for one shared N-bit `regN` register.
- Four requesters each present a request and N-bit write data.
- The block picks one winner, drives the register's write-enable and data for exactly one cycle, then enforces one recovery cycle, so the register is written at most every other clock edge.
- It sits between the requesting units and the `regN` instance; its `reg_wr`/`reg_din` connect directly to the register's `wr`/`data_in`.

## Interface

Parameters:
- `N`, default 8, data width of the shared register.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req`  in  4  per-requester write request; bit i belongs to requester i.
- `req_data`  in  4*N  write data; requester i occupies bits [i*N +: N].
- `gnt`  out  4  one-hot grant; high for exactly the WRITE cycle of the winner.
- `reg_wr`  out  1  write enable to the shared register.
- `reg_din`  out  N  data to the shared register; valid while `reg_wr`=1.
- `owner`  out  2  index of the most recently granted requester.
- `wr_count`  out  8  total writes issued; wraps 255 -> 0.

## Operation

FSM states:
- IDLE:
  - If any `req` bit is high, go to WRITE; otherwise stay in IDLE.
- WRITE:
  - `reg_wr`=1 and `gnt` is the one-hot winner.
  - `reg_din` holds the winner's data, captured at the edge that entered WRITE.
  - Next state is always RECOVER.
- RECOVER:
  - `reg_wr`=0 and `gnt`=0.
  - Arbitration is evaluated again: if any `req` bit is high, go to WRITE; otherwise go to IDLE.

Arbitration:
- The round-robin pointer `ptr` (2 bits) gives highest priority to requester `ptr`, then `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
- The winner is chosen from `req` as sampled at the edge that enters WRITE.
- At the same edge: `ptr` <- winner+1 (mod 4), `owner` <- winner, `wr_count` <- `wr_count`+1 (mod 256).
- Requests are not latched. A `req` bit that drops before it is sampled has no effect.

Requester contract:
- Hold `req` and `req_data` stable until `gnt` is seen.
- Deassert `req` at the edge ending the `gnt` cycle, unless another write is wanted.
- A `req` still high in RECOVER is treated as a new request and competes normally under round-robin.

Reset (`rst`=1 at an edge, in any state):
- State -> IDLE; `ptr`, `owner`, `wr_count` -> 0; `gnt` -> 0; `reg_wr` -> 0; `reg_din` -> 0.
- Reset during WRITE aborts the write: `reg_wr` is 0 from the next cycle. The register has already captured the data on that same edge only if `regN`'s own reset does not take priority.
- Reset overrides any simultaneous request.

## Timing

- All outputs are registered; there are no combinational paths from input to output.
- Latency: `req` high before edge k (FSM in IDLE or RECOVER) -> `gnt`/`reg_wr` high during cycle k..k+1. The register captures `reg_din` at edge k+1.
- Throughput: one write per 2 cycles under continuous load (WRITE, RECOVER alternating); never two consecutive `reg_wr` cycles.
- `reg_wr` and `|gnt` are identical every cycle.
- An isolated request from IDLE reaches WRITE in 1 edge. After RECOVER with no request, there is 1 IDLE cycle minimum before the next WRITE.
- `owner` and `wr_count` update at the edge that enters WRITE and hold otherwise.

## Test plan

1. Reset then idle:
   - Stimulus: `rst`=1 for 2 cycles, `req`=0 for 10 cycles.
   - Required: all outputs 0 throughout; `wr_count`=0.
2. Single request:
   - Stimulus: `req`=4'b0100, data2=8'hA5.
   - Required: next cycle `gnt`=4'b0100, `reg_wr`=1, `reg_din`=8'hA5. Register output = 8'hA5 one edge later. `owner`=2, `wr_count`=1. `reg_wr`=0 in the following cycle.
3. All four requesting continuously:
   - Stimulus: `req`=4'b1111 held high.
   - Required: grant order 0,1,2,3,0,… The `reg_wr` pattern is 1,0,1,0,… `wr_count` increments by 1 every 2 cycles.
4. Fairness after pointer advance:
   - Stimulus: grant requester 1 alone, then assert `req`=4'b0011.
   - Required: requester 0 is granted before requester 1 (`ptr`=2 wraps to 3, 0).
5. Reset mid-write:
   - Stimulus: assert `rst` during a WRITE cycle.
   - Required: next cycle `reg_wr`=0, `gnt`=0. `ptr`, `owner`, `wr_count` = 0. A later `req`=4'b1111 grants requester 0 first.
6. Counter wrap:
   - Stimulus: issue 256 writes.
   - Required: `wr_count` returns to 0 after the 256th WRITE with no other side effect.

Source files
------------

// File: rtl/regn_wr_arbiter.sv
// Round-robin write arbiter for one shared N-bit register: one write cycle per grant,
// always followed by a recovery cycle, with a registered grant/data/owner/count interface.
module regn_wr_arbiter #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] req_data,
  output logic [3:0]     gnt,
  output logic           reg_wr,
  output logic [N-1:0]   reg_din,
  output logic [1:0]     owner,
  output logic [7:0]     wr_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [3:0]   gnt_q, gnt_d;
  logic         reg_wr_q, reg_wr_d;
  logic [N-1:0] reg_din_q, reg_din_d;
  logic [1:0]   owner_q, owner_d;
  logic [7:0]   wr_count_q, wr_count_d;

  logic [1:0]   winner;
  logic [1:0]   cand;
  logic         found;

  // First requester at or after ptr (mod 4) wins.
  always_comb begin
    winner = ptr_q;
    cand   = '0;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = '0;
    reg_wr_d   = 1'b0;
    reg_din_d  = reg_din_q;
    owner_d    = owner_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE, RECOVER: begin
        if (|req) begin
          state_d    = WRITE;
          gnt_d      = 4'b0001 << winner;
          reg_wr_d   = 1'b1;
          reg_din_d  = req_data[int'(winner)*N +: N];
          ptr_d      = winner + 2'd1;
          owner_d    = winner;
          wr_count_d = wr_count_q + 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE:   state_d = RECOVER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      reg_wr_q   <= 1'b0;
      reg_din_q  <= '0;
      owner_q    <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      reg_wr_q   <= reg_wr_d;
      reg_din_q  <= reg_din_d;
      owner_q    <= owner_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign gnt      = gnt_q;
  assign reg_wr   = reg_wr_q;
  assign reg_din  = reg_din_q;
  assign owner    = owner_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regn_wr_arbiter.sv
// Scoreboard bench for regn_wr_arbiter: a behavioural model predicts each write at the
// edge it is issued, and a monitor compares every cycle and pops on each reg_wr.
module tb_regn_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        reg_wr;
  logic [7:0]  reg_din;
  logic [1:0]  owner;
  logic [7:0]  wr_count;

  regn_wr_arbiter #(.N(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .reg_wr   (reg_wr),
    .reg_din  (reg_din),
    .owner    (owner),
    .wr_count (wr_count)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] din;
  } wr_item_t;

  wr_item_t   sb_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 0;

  // Model state: what the outputs should look like after the coming edge.
  int         mdl_ptr     = 0;
  logic [1:0] mdl_owner   = 2'd0;
  logic [7:0] mdl_count   = 8'd0;
  bit         mdl_last_wr = 0;
  bit         mdl_wr_now  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the model to the state after the next edge.
  // A write may never be issued on the edge right after another write.
  task automatic applyStimulus(input logic r, input logic [3:0] q, input logic [31:0] d);
    int       w;
    bit       hit;
    wr_item_t it;
    @(negedge clk);
    rst      = r;
    req      = q;
    req_data = d;
    if (r) begin
      mdl_ptr     = 0;
      mdl_owner   = 2'd0;
      mdl_count   = 8'd0;
      mdl_wr_now  = 0;
    end else if (!mdl_last_wr && (q != 4'b0000)) begin
      w   = 0;
      hit = 0;
      for (int k = 0; k < 4; k++) begin
        if (!hit && q[(mdl_ptr + k) % 4]) begin
          w   = (mdl_ptr + k) % 4;
          hit = 1;
        end
      end
      it.gnt = 4'(1 << w);
      it.din = d[w*8 +: 8];
      sb_q.push_back(it);
      mdl_ptr    = (w + 1) % 4;
      mdl_owner  = 2'(w);
      mdl_count  = mdl_count + 8'd1;
      mdl_wr_now = 1;
    end else begin
      mdl_wr_now = 0;
    end
    mdl_last_wr = mdl_wr_now;
    mon_en      = 1;
  endtask

  task automatic checkOutput();
    wr_item_t it;
    check("reg_wr", 32'(reg_wr), 32'(mdl_wr_now));
    check("owner", 32'(owner), 32'(mdl_owner));
    check("wr_count", 32'(wr_count), 32'(mdl_count));
    if (reg_wr === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_underflow: got reg_wr=1 expected no write at %0t", $time);
      end else begin
        it = sb_q.pop_front();
        check("gnt", 32'(gnt), 32'(it.gnt));
        check("reg_din", 32'(reg_din), 32'(it.din));
      end
    end else begin
      check("gnt_idle", 32'(gnt), 32'd0);
    end
  endtask

  // Monitor: sample one time unit after every rising edge once stimulus has started.
  initial begin
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      checkOutput();
    end
  end

  initial begin
    rst      = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;

    // Reset then idle
    repeat (2)  applyStimulus(1'b1, 4'b0000, 32'h0);
    repeat (10) applyStimulus(1'b0, 4'b0000, 32'h0);

    // Single request from requester 2
    applyStimulus(1'b0, 4'b0100, 32'h00A5_0000);
    repeat (3) applyStimulus(1'b0, 4'b0000, 32'h0);

    // All four requesting continuously
    repeat (16) applyStimulus(1'b0, 4'b1111, $urandom);
    repeat (2)  applyStimulus(1'b0, 4'b0000, 32'h0);

    // Fairness: requester 1 alone, then 0 and 1 together
    applyStimulus(1'b0, 4'b0010, 32'h0000_3300);
    repeat (2) applyStimulus(1'b0, 4'b0000, 32'h0);
    repeat (6) applyStimulus(1'b0, 4'b0011, 32'h0000_4455);
    repeat (2) applyStimulus(1'b0, 4'b0000, 32'h0);

    // Reset landing on a WRITE cycle, then full load restarts at requester 0
    repeat (3) applyStimulus(1'b0, 4'b1111, 32'h1122_3344);
    applyStimulus(1'b1, 4'b1111, 32'h1122_3344);
    repeat (6) applyStimulus(1'b0, 4'b1111, 32'hDEAD_BEEF);

    // Counter wrap: 256 more writes under continuous load
    repeat (512) applyStimulus(1'b0, 4'b1111, $urandom);

    // Random traffic with occasional resets
    for (int c = 0; c < 300; c++)
      applyStimulus(($urandom_range(0, 49) == 0), 4'($urandom), $urandom);

    repeat (3) applyStimulus(1'b0, 4'b0000, 32'h0);
    @(posedge clk);
    #2;
    check("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
